// File: rtl/ethernet_smi_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ethernet_smi_responder_pkg
//  Purpose  : Shared SMI (clause 22) frame constants, field widths and the
//             responder FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package ethernet_smi_responder_pkg;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] ST       = 2'b01;
    localparam logic [1:0] TA_WRITE = 2'b10;

    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int DATA_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ST1   = 3'd1,
        S_OP    = 3'd2,
        S_PHYAD = 3'd3,
        S_REGAD = 3'd4,
        S_TA    = 3'd5,
        S_WDATA = 3'd6,
        S_RDATA = 3'd7
    } smi_state_e;

endpackage
`default_nettype wire

// File: rtl/ethernet_smi_sync.sv
`default_nettype none
// ============================================================================
//  Module   : ethernet_smi_sync
//  Purpose  : Two-flop synchroniser for an asynchronous pad signal plus a
//             rise/fall detector on the synchronised level.
//  Ports    : clk_i    system clock
//             reset_i  synchronous active-high reset
//             async_i  asynchronous input
//             level_o  synchronised level (2 clk latency)
//             rise_o   one-clk pulse on a 0->1 transition of level_o
//             fall_o   one-clk pulse on a 1->0 transition of level_o
//  Revision : 1.0  initial release
// ============================================================================
module ethernet_smi_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // [0],[1] form the synchroniser; [2] is the previous synchronised level.
    logic [2:0] pipe_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= {pipe_q[1:0], async_i};
        end
    end

    assign level_o = pipe_q[1];
    assign rise_o  =  pipe_q[1] & ~pipe_q[2];
    assign fall_o  = ~pipe_q[1] &  pipe_q[2];

endmodule
`default_nettype wire

// File: rtl/ethernet_smi_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ethernet_smi_responder
//  Purpose  : PHY-side MDIO/SMI clause-22 responder. Decodes preamble, ST, OP,
//             PHYAD, REGAD, TA and DATA from a master-driven MDC/MDIO pair;
//             writes become a one-clk strobe, reads fetch user data and drive
//             it back on MDIO.
//  Ports    : clk_i, reset_i      system clock, sync active-high reset
//             mdc_i, mdio_in_i    SMI clock and MDIO pad input (async)
//             mdio_out_o/oe_o     MDIO drive value and output enable
//             wr_en_o/reg_o/data_o  register write strobe, address, data
//             rd_req_o/rd_reg_o   read request strobe and address
//             rd_data_i           read data from user logic
//             busy_o              frame in progress
//             frame_err_o         one-clk pulse on a malformed frame
//  Revision : 1.0  initial release
// ============================================================================
module ethernet_smi_responder
    import ethernet_smi_responder_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR = 5'h01,
    parameter int         PRE_MIN  = 32,
    parameter bit         BCAST_EN = 1'b0
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                mdc_i,
    input  logic                mdio_in_i,
    output logic                mdio_out_o,
    output logic                mdio_oe_o,
    output logic                wr_en_o,
    output logic [REGAD_W-1:0]  wr_reg_o,
    output logic [DATA_W-1:0]   wr_data_o,
    output logic                rd_req_o,
    output logic [REGAD_W-1:0]  rd_reg_o,
    input  logic [DATA_W-1:0]   rd_data_i,
    output logic                busy_o,
    output logic                frame_err_o
);

    localparam logic [5:0] c_PRE_MIN = 6'(PRE_MIN);

    logic w_rise, w_fall, w_mdio;
    logic w_unused_mdc_level, w_unused_mdio_rise, w_unused_mdio_fall;

    ethernet_smi_sync u_sync_mdc (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .async_i (mdc_i),
        .level_o (w_unused_mdc_level),
        .rise_o  (w_rise),
        .fall_o  (w_fall)
    );

    ethernet_smi_sync u_sync_mdio (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .async_i (mdio_in_i),
        .level_o (w_mdio),
        .rise_o  (w_unused_mdio_rise),
        .fall_o  (w_unused_mdio_fall)
    );

    smi_state_e          state_q, state_d;
    logic [5:0]          pre_cnt_q, pre_cnt_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [1:0]          op_q, op_d;
    logic [REGAD_W-1:0]  regad_q, regad_d;
    logic                mdio_out_q, mdio_out_d, mdio_oe_q, mdio_oe_d;
    logic                wr_en_q, wr_en_d, rd_req_q, rd_req_d, frame_err_q, frame_err_d;
    logic [REGAD_W-1:0]  wr_reg_q, wr_reg_d, rd_reg_q, rd_reg_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic [9:0]          w_addr;
    logic                w_rd_hit, w_wr_hit;

    // PHYAD and REGAD share the shift register; on the last REGAD rise the
    // low 9 stored bits plus the current bit form the full 10-bit address.
    assign w_addr   = {shift_q[8:0], w_mdio};
    assign w_rd_hit = (op_q == OP_READ)  && (w_addr[9:5] == PHY_ADDR);
    assign w_wr_hit = (op_q == OP_WRITE) &&
                      ((w_addr[9:5] == PHY_ADDR) || (BCAST_EN && (w_addr[9:5] == 5'h00)));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            pre_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            op_q        <= '0;
            regad_q     <= '0;
            mdio_out_q  <= 1'b1;
            mdio_oe_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
            rd_req_q    <= 1'b0;
            rd_reg_q    <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            op_q        <= op_d;
            regad_q     <= regad_d;
            mdio_out_q  <= mdio_out_d;
            mdio_oe_q   <= mdio_oe_d;
            wr_en_q     <= wr_en_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
            rd_req_q    <= rd_req_d;
            rd_reg_q    <= rd_reg_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        op_d        = op_q;
        regad_d     = regad_q;
        mdio_out_d  = mdio_out_q;
        mdio_oe_d   = mdio_oe_q;
        wr_en_d     = 1'b0;
        wr_reg_d    = wr_reg_q;
        wr_data_d   = wr_data_q;
        rd_req_d    = 1'b0;
        rd_reg_d    = rd_reg_q;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_rise) begin
                    if (w_mdio) begin
                        if (pre_cnt_q < c_PRE_MIN) pre_cnt_d = pre_cnt_q + 6'd1;
                    end else if (pre_cnt_q >= c_PRE_MIN) begin
                        // Clearing here means every frame needs a fresh preamble.
                        state_d   = S_ST1;
                        pre_cnt_d = '0;
                    end else begin
                        pre_cnt_d = '0;
                    end
                end
            end
            S_ST1: begin
                if (w_rise) begin
                    bit_cnt_d = '0;
                    if (w_mdio == ST[0]) begin
                        state_d = S_OP;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_OP: begin
                if (w_rise) begin
                    shift_d = {shift_q[DATA_W-2:0], w_mdio};
                    if (bit_cnt_q == 5'd1) begin
                        op_d      = {shift_q[0], w_mdio};
                        bit_cnt_d = '0;
                        if ({shift_q[0], w_mdio} == OP_WRITE || {shift_q[0], w_mdio} == OP_READ) begin
                            state_d = S_PHYAD;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            S_PHYAD: begin
                if (w_rise) begin
                    shift_d = {shift_q[DATA_W-2:0], w_mdio};
                    if (bit_cnt_q == 5'(PHYAD_W - 1)) begin
                        state_d   = S_REGAD;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            S_REGAD: begin
                if (w_rise) begin
                    shift_d = {shift_q[DATA_W-2:0], w_mdio};
                    if (bit_cnt_q == 5'(REGAD_W - 1)) begin
                        bit_cnt_d = '0;
                        regad_d   = w_addr[4:0];
                        if (w_rd_hit) begin
                            rd_req_d = 1'b1;
                            rd_reg_d = w_addr[4:0];
                            state_d  = S_TA;
                        end else if (w_wr_hit) begin
                            state_d = S_TA;
                        end else begin
                            state_d = S_IDLE;     // not addressed: stay silent
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            S_TA: begin
                if (op_q == OP_WRITE) begin
                    if (w_rise) begin
                        if (w_mdio != TA_WRITE[~bit_cnt_q[0]]) begin
                            frame_err_d = 1'b1;
                            state_d     = S_IDLE;
                        end else if (bit_cnt_q[0]) begin
                            state_d   = S_WDATA;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = 5'd1;
                        end
                    end
                end else begin
                    // bit_cnt 0: waiting for TA1 rise; 1: TA1 seen, drive TA2 on fall.
                    if (w_rise && bit_cnt_q == 5'd0) begin
                        shift_d   = rd_data_i;
                        bit_cnt_d = 5'd1;
                    end else if (w_fall && bit_cnt_q == 5'd1) begin
                        mdio_oe_d  = 1'b1;
                        mdio_out_d = 1'b0;
                        bit_cnt_d  = '0;
                        state_d    = S_RDATA;
                    end
                end
            end
            S_WDATA: begin
                if (w_rise) begin
                    shift_d = {shift_q[DATA_W-2:0], w_mdio};
                    if (bit_cnt_q == 5'(DATA_W - 1)) begin
                        wr_en_d   = 1'b1;
                        wr_reg_d  = regad_q;
                        wr_data_d = {shift_q[DATA_W-2:0], w_mdio};
                        state_d   = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            S_RDATA: begin
                if (w_fall) begin
                    if (bit_cnt_q == 5'(DATA_W)) begin
                        mdio_oe_d  = 1'b0;
                        mdio_out_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        mdio_out_d = shift_q[DATA_W-1];
                        shift_d    = {shift_q[DATA_W-2:0], 1'b0};
                        bit_cnt_d  = bit_cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign mdio_out_o  = mdio_out_q;
    assign mdio_oe_o   = mdio_oe_q;
    assign wr_en_o     = wr_en_q;
    assign wr_reg_o    = wr_reg_q;
    assign wr_data_o   = wr_data_q;
    assign rd_req_o    = rd_req_q;
    assign rd_reg_o    = rd_reg_q;
    assign busy_o      = busy_q;
    assign frame_err_o = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ethernet_smi_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ethernet_smi_responder
//  Purpose  : Directed self-checking bench acting as the SMI master.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ethernet_smi_responder;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        mdc_i = 1'b0;
    logic        mdio_in_i = 1'b1;
    logic        mdio_out_o, mdio_oe_o, wr_en_o, rd_req_o, busy_o, frame_err_o;
    logic [4:0]  wr_reg_o, rd_reg_o;
    logic [15:0] wr_data_o;
    logic [15:0] rd_data_i = 16'h0000;

    int total = 0;
    int bad   = 0;
    int n_wr = 0, n_rd = 0, n_err = 0, n_oe = 0, n_multi = 0;
    int s_wr, s_rd, s_err, s_oe;
    logic [4:0] last_rd_reg = 5'h00;

    ethernet_smi_responder #(.PHY_ADDR(5'h01), .PRE_MIN(32), .BCAST_EN(1'b0)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .mdc_i       (mdc_i),
        .mdio_in_i   (mdio_in_i),
        .mdio_out_o  (mdio_out_o),
        .mdio_oe_o   (mdio_oe_o),
        .wr_en_o     (wr_en_o),
        .wr_reg_o    (wr_reg_o),
        .wr_data_o   (wr_data_o),
        .rd_req_o    (rd_req_o),
        .rd_reg_o    (rd_reg_o),
        .rd_data_i   (rd_data_i),
        .busy_o      (busy_o),
        .frame_err_o (frame_err_o)
    );

    always #5 clk = ~clk;

    // Event counters sampled on the inactive edge.
    always @(negedge clk) begin
        if (!reset_i) begin
            n_wr  += int'(wr_en_o);
            n_rd  += int'(rd_req_o);
            n_err += int'(frame_err_o);
            n_oe  += int'(mdio_oe_o);
            if ((int'(wr_en_o) + int'(rd_req_o) + int'(frame_err_o)) > 1) n_multi++;
            if (rd_req_o) last_rd_reg = rd_reg_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_wr = n_wr; s_rd = n_rd; s_err = n_err; s_oe = n_oe;
    endtask

    // One MDC period (10 clk): data changes with the falling edge.
    task automatic bit_out(input logic b);
        mdc_i = 1'b0; mdio_in_i = b; #50;
        mdc_i = 1'b1; #50;
    endtask

    task automatic send(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bit_out(v[i]);
    endtask

    task automatic header(input int pre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] regad);
        send(32'hFFFF_FFFF, pre > 32 ? 32 : pre);
        if (pre > 32) send(32'hFFFF_FFFF, pre - 32);
        send(32'(2'b01), 2);
        send(32'(op), 2);
        send(32'(phy), 5);
        send(32'(regad), 5);
    endtask

    task automatic write_frame(input int pre, input logic [4:0] phy, input logic [4:0] regad,
                               input logic [1:0] ta, input logic [15:0] data);
        header(pre, 2'b01, phy, regad);
        send(32'(ta), 2);
        send(32'(data), 16);
        #100;
    endtask

    // Read: TA1 released by master, then TA2 + 16 data bits sampled on MDC rise.
    // abort_at >= 0 pulses reset during that bit instead of finishing the frame.
    task automatic read_frame(input int pre, input logic [4:0] regad, input int abort_at,
                              output logic ta2, output logic [15:0] data);
        logic bus;
        ta2 = 1'bx; data = 'x;
        header(pre, 2'b10, 5'h01, regad);
        bit_out(1'b1);
        for (int i = 0; i < 17; i++) begin
            mdc_i = 1'b0; mdio_in_i = 1'b1;
            if (i == abort_at) begin
                #40;
                check("abort_oe_before", 32'(mdio_oe_o), 32'h1);
                reset_i = 1'b1; #10;
                check("abort_oe_next_clk", 32'(mdio_oe_o), 32'h0);
                check("abort_busy", 32'(busy_o), 32'h0);
                reset_i = 1'b0;
                return;
            end
            #50;
            mdc_i = 1'b1;
            bus = mdio_oe_o ? mdio_out_o : 1'b1;
            if (i == 0) ta2 = bus; else data[16 - i] = bus;
            if (i == 0) check("rd_busy_mid", 32'(busy_o), 32'h1);
            #50;
        end
        mdc_i = 1'b0; #100;   // final fall releases the bus
    endtask

    initial begin
        logic        ta2;
        logic [15:0] rdat;

        #23 reset_i = 1'b1;
        #40;
        check("rst_mdio_out", 32'(mdio_out_o), 32'h1);
        check("rst_mdio_oe",  32'(mdio_oe_o),  32'h0);
        check("rst_wr_en",    32'(wr_en_o),    32'h0);
        check("rst_wr_reg",   32'(wr_reg_o),   32'h0);
        check("rst_wr_data",  32'(wr_data_o),  32'h0);
        check("rst_rd_req",   32'(rd_req_o),   32'h0);
        check("rst_rd_reg",   32'(rd_reg_o),   32'h0);
        check("rst_busy",     32'(busy_o),     32'h0);
        check("rst_frame_err",32'(frame_err_o),32'h0);
        @(negedge clk); reset_i = 1'b0; #20;

        // 1: basic write
        snap();
        write_frame(32, 5'h01, 5'h04, 2'b10, 16'hA5C3);
        check("t1_wr_cnt",  32'(n_wr - s_wr), 32'd1);
        check("t1_wr_reg",  32'(wr_reg_o),    32'h04);
        check("t1_wr_data", 32'(wr_data_o),   32'hA5C3);
        check("t1_oe_cnt",  32'(n_oe - s_oe), 32'd0);
        check("t1_err_cnt", 32'(n_err - s_err), 32'd0);

        // 2: basic read
        rd_data_i = 16'h1234;
        snap();
        read_frame(32, 5'h02, -1, ta2, rdat);
        check("t2_rd_cnt",  32'(n_rd - s_rd), 32'd1);
        check("t2_rd_reg",  32'(last_rd_reg), 32'h02);
        check("t2_ta2",     32'(ta2),         32'h0);
        check("t2_data",    32'(rdat),        32'h1234);
        check("t2_oe_clks", 32'(n_oe - s_oe), 32'd170);
        check("t2_oe_end",  32'(mdio_oe_o),   32'h0);
        check("t2_wr_cnt",  32'(n_wr - s_wr), 32'd0);

        // 3: other PHY ignored silently, then an immediate valid frame
        snap();
        write_frame(32, 5'h05, 5'h07, 2'b10, 16'hDEAD);
        check("t3_wr_cnt",  32'(n_wr - s_wr),   32'd0);
        check("t3_rd_cnt",  32'(n_rd - s_rd),   32'd0);
        check("t3_err_cnt", 32'(n_err - s_err), 32'd0);
        check("t3_oe_cnt",  32'(n_oe - s_oe),   32'd0);
        snap();
        write_frame(32, 5'h01, 5'h1F, 2'b10, 16'h0F0F);
        check("t3b_wr_cnt", 32'(n_wr - s_wr), 32'd1);
        check("t3b_wr_reg", 32'(wr_reg_o),    32'h1F);
        check("t3b_wr_data",32'(wr_data_o),   32'h0F0F);

        // 4: preamble length boundary
        snap();
        write_frame(31, 5'h01, 5'h03, 2'b10, 16'h5555);
        check("t4_short_wr",  32'(n_wr - s_wr),   32'd0);
        check("t4_short_err", 32'(n_err - s_err), 32'd0);
        check("t4_short_reg", 32'(wr_reg_o),      32'h1F);
        snap();
        write_frame(40, 5'h01, 5'h03, 2'b10, 16'h5555);
        check("t4_long_wr",   32'(n_wr - s_wr), 32'd1);
        check("t4_long_reg",  32'(wr_reg_o),    32'h03);
        check("t4_long_data", 32'(wr_data_o),   32'h5555);

        // 5: bad opcode, then bad write turnaround
        snap();
        send(32'hFFFF_FFFF, 32);
        send(32'(2'b01), 2);
        #50;
        check("t5_busy_after_st", 32'(busy_o), 32'h1);
        send(32'(2'b11), 2);
        #100;
        check("t5_op_err",  32'(n_err - s_err), 32'd1);
        check("t5_op_busy", 32'(busy_o),        32'h0);
        snap();
        write_frame(32, 5'h01, 5'h06, 2'b11, 16'hFFFF);
        check("t5_ta_err",  32'(n_err - s_err), 32'd1);
        check("t5_ta_wr",   32'(n_wr - s_wr),   32'd0);
        check("t5_ta_data", 32'(wr_data_o),     32'h5555);

        // 6: reset during read data, then a full read
        rd_data_i = 16'hC3A5;
        read_frame(32, 5'h09, 8, ta2, rdat);
        snap();
        #200;
        check("t6_quiet_wr",  32'(n_wr - s_wr),   32'd0);
        check("t6_quiet_err", 32'(n_err - s_err), 32'd0);
        rd_data_i = 16'hBEEF;
        snap();
        read_frame(32, 5'h11, -1, ta2, rdat);
        check("t6_rd_cnt", 32'(n_rd - s_rd), 32'd1);
        check("t6_rd_reg", 32'(last_rd_reg), 32'h11);
        check("t6_ta2",    32'(ta2),         32'h0);
        check("t6_data",   32'(rdat),        32'hBEEF);

        check("strobe_exclusive", 32'(n_multi), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
